ms_riscv32_mp_irq_ctrl: RTL and testbench
=========================================

MS_RISCV32_MP_IRQ_CTRL -- requirements
Module: ms_riscv32_mp_irq_ctrl

Interface
REQ-001 Parameter NUM_EIRQ, default 8, number of external interrupt channels (legal range 1..31).
REQ-002 Parameter PRIO_W, default 3, priority field width per channel.
REQ-003 Parameter EDGE_MASK, default all-zero, NUM_EIRQ bits; bit n=1 makes channel n edge-triggered, 0 level-triggered.
REQ-004 One clock; reset is asynchronous and active-high. Both are listed first below.
REQ-005 ms_riscv32_mp_clk_in  input  1  core clock; all state updates on its rising edge.
REQ-006 ms_riscv32_mp_rst_in  input  1  asynchronous, active-high reset.
REQ-007 ms_riscv32_mp_eirq_in  input  NUM_EIRQ  asynchronous external interrupt lines.
REQ-008 ms_riscv32_mp_tirq_in / ms_riscv32_mp_sirq_in  input  1 each  timer / software interrupt levels, synchronous.
REQ-009 ms_riscv32_mp_cfg_wr_in  input  1  config write strobe.
REQ-010 ms_riscv32_mp_cfg_addr_in  input  6  config register index.
REQ-011 ms_riscv32_mp_cfg_wdata_in  input  32  config write data.
REQ-012 ms_riscv32_mp_cfg_rdata_out  output  32  config read data, one-cycle latency.
REQ-013 ms_riscv32_mp_claim_in  input  1  single-cycle claim pulse from core.
REQ-014 ms_riscv32_mp_complete_in  input  1  single-cycle completion pulse.
REQ-015 ms_riscv32_mp_complete_id_in  input  5  ID being completed.
REQ-016 ms_riscv32_mp_irq_req_out  output  1  interrupt request to core, registered.
REQ-017 ms_riscv32_mp_irq_cause_out  output  32  mcause value: 0x8000000B external, 0x80000003 software, 0x80000007 timer.
REQ-018 ms_riscv32_mp_irq_id_out  output  5  winning external ID (channel n = n+1; 0 = none).
REQ-019 ms_riscv32_mp_claim_id_out  output  5  ID returned one cycle after a claim.

Function
REQ-020 Each eirq line SHALL pass a 2-flop synchroniser; line high before edge E0 -> pending after E2 -> irq_req_out high after E3.
REQ-021 Per-channel FSM SHALL be IDLE -> PENDING (level high, or rising edge in edge mode) -> IN_SERVICE (claim) -> IDLE on complete, or PENDING on complete if level still high or an edge arrived meanwhile.
REQ-022 An edge arriving while IN_SERVICE SHALL be latched (one deep) and delivered after complete; further edges are lost.
REQ-023 A level channel dropping while PENDING SHALL return to IDLE.
REQ-024 Arbitration: eligible = PENDING, enabled, priority > threshold; highest priority wins; tie goes to lowest channel index; priority 0 never wins.
REQ-025 Core-level order: external > software > timer, each gated by its enable bit; irq_req_out = any eligible source.
REQ-026 Config map: index 0..NUM_EIRQ-1 = channel priority [PRIO_W-1:0]; 32 = enable mask; 33 = threshold; 34 = {sie bit1, tie bit0}; 35 = pending vector (read-only); other indices read 0, writes ignored.
REQ-027 A config write SHALL take effect for arbitration in the cycle after the strobe.
REQ-028 Claim SHALL move the current irq_id_out channel to IN_SERVICE and drive claim_id_out with that ID next cycle; claim with ID 0 returns 0 and changes nothing.
REQ-029 Complete with ID 0, out of range, or a channel not IN_SERVICE SHALL be ignored.
REQ-030 Claim and complete of the same ID in one cycle: complete applies first, then claim; net state IN_SERVICE.
REQ-031 Claim and complete SHALL NOT clear timer/software sources; those follow their input levels.

Reset
REQ-032 Reset SHALL asynchronously clear synchronisers, FSMs to IDLE, priorities, enable, threshold and sie/tie to 0, and all outputs to 0.
REQ-033 Reset asserted mid-service SHALL discard all pending and in-service state; no request after release until a fresh source event.

Structure
REQ-034 Cause codes, config indices and FSM state encoding SHALL live in shared package ms_riscv32_mp_pkg.
REQ-035 The per-channel synchroniser, edge detect and FSM SHALL be sub-module ms_riscv32_mp_irq_gateway, instantiated NUM_EIRQ times; arbitration stays in the top.

Verification
REQ-036 Ch2 priority 5, enabled, threshold 0; pulse eirq[2] -> irq_req_out high 4 edges later, id 3, cause 0x8000000B.
REQ-037 Ch1 and ch4 both priority 3 and pending -> id 2; ch4 set to priority 6 -> id 5 next cycle.
REQ-038 Edge ch0 claimed; second edge during service; complete id 1 -> irq_req_out reasserts with id 1.
REQ-039 tirq and sirq high, both enabled, no external -> cause 0x80000003; sirq drops -> 0x80000007.
REQ-040 Claim id 3 then complete id 7 (not in service) -> ignored, ch2 stays IN_SERVICE; reset mid-service -> all outputs 0.

Source files
------------

// File: rtl/ms_riscv32_mp_pkg.sv
// Shared constants for the ms_riscv32_mp interrupt controller:
// mcause codes, configuration register indices and gateway FSM encoding.
package ms_riscv32_mp_pkg;

  localparam int ID_W = 5;

  // mcause values presented to the core
  localparam logic [31:0] CAUSE_NONE = 32'h0000_0000;
  localparam logic [31:0] CAUSE_EXT  = 32'h8000_000B;
  localparam logic [31:0] CAUSE_SW   = 32'h8000_0003;
  localparam logic [31:0] CAUSE_TMR  = 32'h8000_0007;

  // Configuration register indices (0..NUM_EIRQ-1 are channel priorities)
  localparam logic [5:0] CFG_ENABLE  = 6'd32;
  localparam logic [5:0] CFG_THRESH  = 6'd33;
  localparam logic [5:0] CFG_CORE_EN = 6'd34;
  localparam logic [5:0] CFG_PENDING = 6'd35;

  // Gateway FSM encoding
  localparam logic [1:0] GW_IDLE = 2'd0;
  localparam logic [1:0] GW_PEND = 2'd1;
  localparam logic [1:0] GW_INSV = 2'd2;

endpackage

// File: rtl/ms_riscv32_mp_irq_gateway.sv
// Per-channel interrupt gateway: two-flop synchroniser, rising-edge detect,
// and the IDLE/PENDING/IN_SERVICE lifecycle with a one-deep edge latch.
module ms_riscv32_mp_irq_gateway
  import ms_riscv32_mp_pkg::*;
#(
  parameter bit EDGE = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic irq_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic pending_o
);

  logic       sync1_q, sync2_q, prev_q;
  logic       latch_q, latch_d;
  logic [1:0] state_q, state_d;
  logic       rise, trig;

  assign rise = sync2_q & ~prev_q;
  assign trig = EDGE ? rise : sync2_q;

  // Synchronise the asynchronous line and keep the previous sample for edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Next-state logic; a complete is applied before a simultaneous claim
  always_comb begin
    state_d = state_q;
    latch_d = latch_q;
    case (state_q)
      GW_IDLE: begin
        if (trig) state_d = GW_PEND;
      end
      GW_PEND: begin
        if (claim_i)                state_d = GW_INSV;
        else if (!EDGE && !sync2_q) state_d = GW_IDLE;
      end
      GW_INSV: begin
        if (complete_i) begin
          latch_d = 1'b0;
          if (claim_i)                                 state_d = GW_INSV;
          else if (EDGE ? (latch_q | rise) : sync2_q) state_d = GW_PEND;
          else                                         state_d = GW_IDLE;
        end else if (EDGE && rise) begin
          latch_d = 1'b1;
        end
      end
      default: state_d = GW_IDLE;
    endcase
  end

  // State and edge-latch registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= GW_IDLE;
      latch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      latch_q <= latch_d;
    end
  end

  assign pending_o = (state_q == GW_PEND);

endmodule

// File: rtl/ms_riscv32_mp_irq_ctrl.sv
// Interrupt controller for the ms_riscv32_mp core: per-channel gateways,
// priority/threshold arbitration, core-level source ordering and config regs.
module ms_riscv32_mp_irq_ctrl
  import ms_riscv32_mp_pkg::*;
#(
  parameter int                  NUM_EIRQ  = 8,
  parameter int                  PRIO_W    = 3,
  parameter logic [NUM_EIRQ-1:0] EDGE_MASK = '0
) (
  input  logic                ms_riscv32_mp_clk_in,
  input  logic                ms_riscv32_mp_rst_in,
  input  logic [NUM_EIRQ-1:0] ms_riscv32_mp_eirq_in,
  input  logic                ms_riscv32_mp_tirq_in,
  input  logic                ms_riscv32_mp_sirq_in,
  input  logic                ms_riscv32_mp_cfg_wr_in,
  input  logic [5:0]          ms_riscv32_mp_cfg_addr_in,
  input  logic [31:0]         ms_riscv32_mp_cfg_wdata_in,
  output logic [31:0]         ms_riscv32_mp_cfg_rdata_out,
  input  logic                ms_riscv32_mp_claim_in,
  input  logic                ms_riscv32_mp_complete_in,
  input  logic [ID_W-1:0]     ms_riscv32_mp_complete_id_in,
  output logic                ms_riscv32_mp_irq_req_out,
  output logic [31:0]         ms_riscv32_mp_irq_cause_out,
  output logic [ID_W-1:0]     ms_riscv32_mp_irq_id_out,
  output logic [ID_W-1:0]     ms_riscv32_mp_claim_id_out
);

  logic              clk, rst;
  logic [PRIO_W-1:0] prio_q [NUM_EIRQ];
  logic [NUM_EIRQ-1:0] en_q;
  logic [PRIO_W-1:0] thr_q;
  logic              sie_q, tie_q;

  logic [NUM_EIRQ-1:0] pend_vec, claim_vec, cmpl_vec;
  logic [PRIO_W-1:0] win_prio;
  logic [ID_W-1:0]   win_id;
  logic              ext_req, sw_req, tm_req;

  logic              req_q, req_d;
  logic [31:0]       cause_q, cause_d;
  logic [ID_W-1:0]   id_q, claim_id_q;
  logic [31:0]       rdata_q, rdata_d;
  logic              unused_wdata;

  assign clk = ms_riscv32_mp_clk_in;
  assign rst = ms_riscv32_mp_rst_in;
  // Only the low bits of write data are stored; the rest are deliberately dropped
  assign unused_wdata = ^ms_riscv32_mp_cfg_wdata_in;

  // One gateway per external line; claim targets the currently presented ID
  for (genvar n = 0; n < NUM_EIRQ; n++) begin : g_gw
    assign claim_vec[n] = ms_riscv32_mp_claim_in && (id_q == ID_W'(n + 1));
    assign cmpl_vec[n]  = ms_riscv32_mp_complete_in &&
                          (ms_riscv32_mp_complete_id_in == ID_W'(n + 1));
    ms_riscv32_mp_irq_gateway #(.EDGE(EDGE_MASK[n])) u_gw (
      .clk_i      (clk),
      .rst_i      (rst),
      .irq_i      (ms_riscv32_mp_eirq_in[n]),
      .claim_i    (claim_vec[n]),
      .complete_i (cmpl_vec[n]),
      .pending_o  (pend_vec[n])
    );
  end

  // Highest priority above threshold wins; strict compare keeps the lowest index on ties
  always_comb begin
    win_prio = '0;
    win_id   = '0;
    for (int n = 0; n < NUM_EIRQ; n++) begin
      if (pend_vec[n] && en_q[n] && (prio_q[n] > thr_q) && (prio_q[n] > win_prio)) begin
        win_prio = prio_q[n];
        win_id   = ID_W'(n + 1);
      end
    end
  end

  assign ext_req = (win_id != '0);
  assign sw_req  = ms_riscv32_mp_sirq_in & sie_q;
  assign tm_req  = ms_riscv32_mp_tirq_in & tie_q;
  assign req_d   = ext_req | sw_req | tm_req;

  // Core-level ordering: external, then software, then timer
  always_comb begin
    cause_d = CAUSE_NONE;
    if (ext_req)     cause_d = CAUSE_EXT;
    else if (sw_req) cause_d = CAUSE_SW;
    else if (tm_req) cause_d = CAUSE_TMR;
  end

  // Registered request, cause, winning ID and claim response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q      <= 1'b0;
      cause_q    <= CAUSE_NONE;
      id_q       <= '0;
      claim_id_q <= '0;
    end else begin
      req_q   <= req_d;
      cause_q <= cause_d;
      id_q    <= win_id;
      if (ms_riscv32_mp_claim_in) claim_id_q <= id_q;
    end
  end

  // Configuration register writes; unmapped indices are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NUM_EIRQ; n++) prio_q[n] <= '0;
      en_q  <= '0;
      thr_q <= '0;
      sie_q <= 1'b0;
      tie_q <= 1'b0;
    end else if (ms_riscv32_mp_cfg_wr_in) begin
      for (int n = 0; n < NUM_EIRQ; n++) begin
        if (ms_riscv32_mp_cfg_addr_in == 6'(n)) prio_q[n] <= ms_riscv32_mp_cfg_wdata_in[PRIO_W-1:0];
      end
      case (ms_riscv32_mp_cfg_addr_in)
        CFG_ENABLE:  en_q  <= ms_riscv32_mp_cfg_wdata_in[NUM_EIRQ-1:0];
        CFG_THRESH:  thr_q <= ms_riscv32_mp_cfg_wdata_in[PRIO_W-1:0];
        CFG_CORE_EN: {sie_q, tie_q} <= ms_riscv32_mp_cfg_wdata_in[1:0];
        default: ;
      endcase
    end
  end

  // Read mux; unmapped indices return zero
  always_comb begin
    rdata_d = '0;
    for (int n = 0; n < NUM_EIRQ; n++) begin
      if (ms_riscv32_mp_cfg_addr_in == 6'(n)) rdata_d = 32'(prio_q[n]);
    end
    case (ms_riscv32_mp_cfg_addr_in)
      CFG_ENABLE:  rdata_d = 32'(en_q);
      CFG_THRESH:  rdata_d = 32'(thr_q);
      CFG_CORE_EN: rdata_d = {30'b0, sie_q, tie_q};
      CFG_PENDING: rdata_d = 32'(pend_vec);
      default: ;
    endcase
  end

  // Read data register gives the one-cycle read latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign ms_riscv32_mp_cfg_rdata_out  = rdata_q;
  assign ms_riscv32_mp_irq_req_out    = req_q;
  assign ms_riscv32_mp_irq_cause_out  = cause_q;
  assign ms_riscv32_mp_irq_id_out     = id_q;
  assign ms_riscv32_mp_claim_id_out   = claim_id_q;

endmodule

// File: tb/tb_ms_riscv32_mp_irq_ctrl.sv
// Scoreboard bench for ms_riscv32_mp_irq_ctrl: stimulus pushes expected
// output values tagged with a target cycle; a monitor compares on negedge.
module tb_ms_riscv32_mp_irq_ctrl;

  localparam int NE = 8;
  localparam int K_REQ = 0, K_CAUSE = 1, K_ID = 2, K_CLAIM = 3, K_RDATA = 4;
  localparam logic [31:0] C_EXT = 32'h8000000B, C_SW = 32'h80000003, C_TMR = 32'h80000007;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NE-1:0] eirq = '0;
  logic          tirq = 1'b0, sirq = 1'b0;
  logic          cfg_wr = 1'b0;
  logic [5:0]    cfg_addr = '0;
  logic [31:0]   cfg_wdata = '0;
  logic [31:0]   cfg_rdata;
  logic          claim = 1'b0, complete = 1'b0;
  logic [4:0]    complete_id = '0;
  logic          irq_req;
  logic [31:0]   irq_cause;
  logic [4:0]    irq_id, claim_id;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  int          q_cyc[$];
  int          q_kind[$];
  logic [31:0] q_exp[$];
  string       q_name[$];

  ms_riscv32_mp_irq_ctrl #(.NUM_EIRQ(NE), .PRIO_W(3), .EDGE_MASK(8'h01)) dut (
    .ms_riscv32_mp_clk_in         (clk),
    .ms_riscv32_mp_rst_in         (rst),
    .ms_riscv32_mp_eirq_in        (eirq),
    .ms_riscv32_mp_tirq_in        (tirq),
    .ms_riscv32_mp_sirq_in        (sirq),
    .ms_riscv32_mp_cfg_wr_in      (cfg_wr),
    .ms_riscv32_mp_cfg_addr_in    (cfg_addr),
    .ms_riscv32_mp_cfg_wdata_in   (cfg_wdata),
    .ms_riscv32_mp_cfg_rdata_out  (cfg_rdata),
    .ms_riscv32_mp_claim_in       (claim),
    .ms_riscv32_mp_complete_in    (complete),
    .ms_riscv32_mp_complete_id_in (complete_id),
    .ms_riscv32_mp_irq_req_out    (irq_req),
    .ms_riscv32_mp_irq_cause_out  (irq_cause),
    .ms_riscv32_mp_irq_id_out     (irq_id),
    .ms_riscv32_mp_claim_id_out   (claim_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int kind);
    case (kind)
      K_REQ:   return {31'b0, irq_req};
      K_CAUSE: return irq_cause;
      K_ID:    return {27'b0, irq_id};
      K_CLAIM: return {27'b0, claim_id};
      default: return cfg_rdata;
    endcase
  endfunction

  // Monitor: compare every expectation whose target cycle has arrived
  always @(negedge clk) begin
    for (int i = q_cyc.size() - 1; i >= 0; i--) begin
      if (q_cyc[i] <= cyc) begin
        logic [31:0] a;
        a = actual(q_kind[i]);
        checks++;
        if (q_cyc[i] < cyc) begin
          failures++;
          $display("FAIL %s: check missed (target cycle %0d, now %0d)", q_name[i], q_cyc[i], cyc);
        end else if (a !== q_exp[i]) begin
          failures++;
          $display("FAIL %s: got %h, want %h (cycle %0d)", q_name[i], a, q_exp[i], cyc);
        end
        q_cyc.delete(i); q_kind.delete(i); q_exp.delete(i); q_name.delete(i);
      end
    end
  end

  task automatic exp_push(input int kind, input int dly, input logic [31:0] v, input string name);
    q_cyc.push_back(cyc + dly);
    q_kind.push_back(kind);
    q_exp.push_back(v);
    q_name.push_back(name);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [5:0] a, input logic [31:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick(1);
    cfg_wr = 1'b0;
  endtask

  task automatic cfg_read_check(input logic [5:0] a, input logic [31:0] v, input string name);
    cfg_addr = a;
    exp_push(K_RDATA, 1, v, name);
    tick(1);
  endtask

  task automatic do_claim(input logic [4:0] v, input string name);
    claim = 1'b1;
    exp_push(K_CLAIM, 1, {27'b0, v}, name);
    tick(1);
    claim = 1'b0;
  endtask

  task automatic do_complete(input logic [4:0] id);
    complete = 1'b1; complete_id = id;
    tick(1);
    complete = 1'b0; complete_id = '0;
  endtask

  task automatic pulse_e0();
    eirq[0] = 1'b1; tick(2);
    eirq[0] = 1'b0; tick(2);
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    // Reset state
    exp_push(K_REQ, 0, 0, "rst_req");
    exp_push(K_CAUSE, 0, 0, "rst_cause");
    exp_push(K_ID, 0, 0, "rst_id");
    exp_push(K_CLAIM, 0, 0, "rst_claim_id");
    cfg_read_check(CFG_EN_IDX(), 0, "rst_enable");

    // Configuration and readback
    cfg_write(2, 5);
    cfg_write(32, 32'hFF);
    cfg_write(33, 0);
    cfg_read_check(2, 5, "prio2_rd");
    cfg_read_check(32, 32'hFF, "enable_rd");
    cfg_write(40, 32'hFFFF_FFFF);
    cfg_read_check(40, 0, "unmapped_rd");

    // Level channel 2: request 4 edges after the line rises
    eirq[2] = 1'b1;
    exp_push(K_REQ, 3, 0, "ch2_req_before_e3");
    exp_push(K_REQ, 4, 1, "ch2_req");
    exp_push(K_ID, 4, 3, "ch2_id");
    exp_push(K_CAUSE, 4, C_EXT, "ch2_cause");
    tick(4);
    cfg_read_check(35, 32'h4, "pending_vec");

    // Claim, bogus complete, real complete with level still high
    exp_push(K_REQ, 2, 0, "req_drop_after_claim");
    do_claim(3, "claim_ch2");
    exp_push(K_REQ, 3, 0, "cmpl7_ignored");
    do_complete(7);
    tick(1);
    cfg_read_check(35, 0, "pend_in_service");
    exp_push(K_REQ, 2, 1, "cmpl3_reissue");
    exp_push(K_ID, 2, 3, "cmpl3_reissue_id");
    do_complete(3);
    tick(1);

    // Level drop while pending returns to idle
    eirq[2] = 1'b0;
    exp_push(K_REQ, 3, 1, "level_hold");
    exp_push(K_REQ, 4, 0, "level_drop_idle");
    tick(4);

    // Tie-break, priority change, threshold, enable, priority 0
    cfg_write(1, 3);
    cfg_write(4, 3);
    eirq[1] = 1'b1; eirq[4] = 1'b1;
    exp_push(K_ID, 4, 2, "tie_low_idx");
    tick(4);
    exp_push(K_ID, 1, 2, "tie_before_write");
    exp_push(K_ID, 2, 5, "prio_raise_next");
    cfg_write(4, 6);
    tick(1);
    exp_push(K_REQ, 2, 0, "thr_blocks");
    cfg_write(33, 6);
    tick(1);
    exp_push(K_ID, 2, 5, "thr_lowered");
    cfg_write(33, 2);
    tick(1);
    exp_push(K_ID, 2, 2, "en_mask_ch4");
    cfg_write(32, 32'hEF);
    tick(1);
    exp_push(K_REQ, 2, 0, "prio0_never");
    cfg_write(1, 0);
    tick(1);
    eirq[1] = 1'b0; eirq[4] = 1'b0;
    exp_push(K_REQ, 6, 0, "cleanup_idle");
    cfg_write(32, 32'hFF);
    cfg_write(33, 0);
    tick(4);

    // Edge channel 0: latch one edge during service, drop further ones
    cfg_write(0, 2);
    exp_push(K_REQ, 3, 0, "edge_before_e3");
    exp_push(K_REQ, 4, 1, "edge_req");
    exp_push(K_ID, 4, 1, "edge_id");
    pulse_e0();
    exp_push(K_REQ, 2, 0, "edge_claimed");
    do_claim(1, "claim_ch0");
    tick(1);
    pulse_e0();
    exp_push(K_REQ, 0, 0, "edge_latched_quiet");
    cfg_read_check(35, 0, "edge_not_pending");
    exp_push(K_REQ, 2, 1, "edge_redeliver");
    exp_push(K_ID, 2, 1, "edge_redeliver_id");
    do_complete(1);
    tick(1);
    exp_push(K_REQ, 2, 0, "edge_claimed_b");
    do_claim(1, "claim_ch0_b");
    pulse_e0();
    pulse_e0();
    exp_push(K_REQ, 2, 1, "one_deep_latch");
    do_complete(1);
    tick(1);
    exp_push(K_REQ, 2, 0, "edge_claimed_c");
    do_claim(1, "claim_ch0_c");
    exp_push(K_REQ, 3, 0, "extra_edge_lost");
    do_complete(1);
    tick(3);

    // Software and timer sources
    cfg_write(34, 3);
    tirq = 1'b1; sirq = 1'b1;
    exp_push(K_CAUSE, 1, C_SW, "sw_over_timer");
    exp_push(K_REQ, 1, 1, "sw_req");
    tick(2);
    sirq = 1'b0;
    exp_push(K_CAUSE, 1, C_TMR, "timer_cause");
    tick(1);
    exp_push(K_REQ, 2, 1, "timer_survives_claim");
    do_claim(0, "claim_none");
    tick(1);
    exp_push(K_REQ, 2, 0, "tie_gate");
    cfg_write(34, 2);
    tick(1);
    cfg_write(34, 3);
    eirq[2] = 1'b1;
    exp_push(K_CAUSE, 4, C_EXT, "ext_over_timer");
    exp_push(K_ID, 4, 3, "ext_over_timer_id");
    tick(4);

    // Reset in the middle of service with another channel pending
    do_claim(3, "claim_pre_reset");
    exp_push(K_ID, 4, 1, "ch0_pending_pre_rst");
    pulse_e0();
    tick(1);
    tirq = 1'b0; eirq = '0;
    rst = 1'b1;
    exp_push(K_REQ, 0, 0, "rst_async_req");
    exp_push(K_CAUSE, 0, 0, "rst_async_cause");
    exp_push(K_ID, 0, 0, "rst_async_id");
    exp_push(K_CLAIM, 0, 0, "rst_async_claim");
    exp_push(K_RDATA, 0, 0, "rst_async_rdata");
    tick(2);
    rst = 1'b0;
    cfg_read_check(0, 0, "prio_cleared");
    cfg_read_check(34, 0, "core_en_cleared");
    cfg_write(0, 2);
    cfg_write(32, 32'hFF);
    exp_push(K_REQ, 2, 0, "no_stale_pending");
    tick(3);
    exp_push(K_REQ, 4, 1, "fresh_event");
    exp_push(K_ID, 4, 1, "fresh_event_id");
    pulse_e0();
    tick(2);

    // Drain any outstanding expectations within a bounded window
    for (int i = 0; i < 20 && q_cyc.size() > 0; i++) @(negedge clk);
    #1;
    while (q_cyc.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s: never evaluated (target cycle %0d)", q_name[0], q_cyc[0]);
      void'(q_cyc.pop_front()); void'(q_kind.pop_front());
      void'(q_exp.pop_front()); void'(q_name.pop_front());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic [5:0] CFG_EN_IDX();
    return 6'd32;
  endfunction

endmodule
